// File: rtl/axi_wr_mem_pkg.sv
// Shared types and constants for the AXI4 write-path memory slave.
`timescale 1ns/1ps
package axi_wr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_wr_mem_ram.sv
// Byte-enabled single-write-port RAM with a combinational read port.
// Contents are never reset.
`timescale 1ns/1ps
module axi_wr_mem_ram #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [MEM_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic [MEM_ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_wr_mem_slave.sv
// AXI4 write-path memory slave: one burst at a time into a byte-enabled RAM.
// Optional macro AXI_WR_MEM_BP_EN inserts one wready stall cycle in every four.
`timescale 1ns/1ps
module axi_wr_mem_slave
  import axi_wr_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [MEM_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF        = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;

  state_t                    state, state_nxt;
  logic [ID_WIDTH-1:0]       id_q;
  logic [MEM_ADDR_WIDTH-1:0] idx_q;
  logic [7:0]                len_q;
  logic                      fixed_q;
  logic [7:0]                cnt_q;
  logic                      err_q;
  logic                      aw_hs, w_hs, b_hs, last_beat, beat_err;
  logic                      unused_addr;

  // Upper address bits alias onto the memory; only the word index is kept.
  assign unused_addr = ^s_axi_awaddr;

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign b_hs      = s_axi_bvalid && s_axi_bready;
  assign last_beat = (cnt_q == len_q);
  assign beat_err  = last_beat ? !s_axi_wlast : s_axi_wlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (aw_hs) state_nxt = WDATA;
      WDATA:   if (w_hs && last_beat) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign s_axi_awready = (state == IDLE) && !reset;
  assign s_axi_bvalid  = (state == RESP);

`ifdef AXI_WR_MEM_BP_EN
  logic [1:0] bp_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bp_cnt <= 2'd0;
    else       bp_cnt <= bp_cnt + 2'd1;
  end

  assign s_axi_wready = (state == WDATA) && (bp_cnt != 2'd3);
`else
  assign s_axi_wready = (state == WDATA);
`endif

  // Control: beat counter, error flag and the response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      s_axi_bid   <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else if (aw_hs) begin
      cnt_q <= 8'd0;
      err_q <= (s_axi_awburst == BURST_WRAP) || (s_axi_awburst == BURST_RSVD);
    end else if (w_hs) begin
      err_q <= err_q || beat_err;
      if (last_beat) begin
        s_axi_bid   <= id_q;
        s_axi_bresp <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Burst context: reloaded on every AW handshake, so no reset needed.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      id_q    <= s_axi_awid;
      idx_q   <= s_axi_awaddr[MEM_ADDR_WIDTH+OFF-1:OFF];
      len_q   <= s_axi_awlen;
      fixed_q <= (s_axi_awburst == BURST_FIXED);
    end else if (w_hs && !fixed_q) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  axi_wr_mem_ram #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_hs),
    .waddr (idx_q),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .raddr (dbg_addr),
    .rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_axi_wr_mem_slave.sv
// Self-checking bench for axi_wr_mem_slave with a byte-level memory model.
`timescale 1ns/1ps
module tb_axi_wr_mem_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [9:0]  dbg_addr = '0;
  logic [31:0] dbg_rdata;

  int tests = 0;
  int fails = 0;

  // Reference model: expected bytes plus a mask of bytes ever written.
  logic [31:0] ref_mem  [1024];
  logic [31:0] ref_mask [1024];

  logic [31:0] bd [256];
  logic [3:0]  bs [256];
  logic        bl [256];
  logic        exp_err;

  always #5 clk = ~clk;

  axi_wr_mem_slave dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awburst (awburst),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .dbg_addr      (dbg_addr),
    .dbg_rdata     (dbg_rdata)
  );

  task automatic fill(input int len, input bit full_strb);
    for (int i = 0; i <= len; i++) begin
      bd[i] = $urandom;
      bs[i] = full_strb ? 4'hF : 4'($urandom);
      bl[i] = (i == len);
    end
  endtask

  task automatic send_aw(input [7:0] id, input [31:0] addr, input [7:0] len, input [1:0] burst);
    int n;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (!awready) begin
      tests++; fails++;
      $display("FAIL aw_timeout: awready=%b required 1", awready);
    end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  // Drives beats 0..count-1 of a burst and folds them into the model.
  task automatic send_w(input [31:0] addr, input int len, input [1:0] burst, input int count);
    int n;
    int word;
    exp_err = burst[1];
    for (int i = 0; i < count; i++) begin
      wdata = bd[i]; wstrb = bs[i]; wlast = bl[i]; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      if (!wready) begin
        tests++; fails++;
        $display("FAIL w_timeout beat %0d: wready=%b required 1", i, wready);
        break;
      end
      @(negedge clk);
      word = (int'(addr[11:2]) + ((burst == 2'b00) ? 0 : i)) % 1024;
      for (int b = 0; b < 4; b++) begin
        if (bs[i][b]) begin
          ref_mem[word][b*8 +: 8]  = bd[i][b*8 +: 8];
          ref_mask[word][b*8 +: 8] = 8'hFF;
        end
      end
      if (bl[i] != (i == len)) exp_err = 1'b1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b(input int delay, output logic [7:0] id, output logic [1:0] resp);
    int n;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    id = bid; resp = bresp;
    if (!bvalid) begin
      tests++; fails++;
      $display("FAIL b_timeout: bvalid=%b required 1", bvalid);
      return;
    end
    repeat (delay) @(negedge clk);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic rd(input [9:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_rdata;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (awready !== 1'b0) begin fails++; $display("FAIL rst_awready: got %b required 0", awready); end
    tests++; if (wready !== 1'b0)  begin fails++; $display("FAIL rst_wready: got %b required 0", wready); end
    tests++; if (bvalid !== 1'b0)  begin fails++; $display("FAIL rst_bvalid: got %b required 0", bvalid); end
    tests++; if (bid !== 8'h00)    begin fails++; $display("FAIL rst_bid: got %h required 00", bid); end
    tests++; if (bresp !== 2'b00)  begin fails++; $display("FAIL rst_bresp: got %b required 00", bresp); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (awready !== 1'b1) begin fails++; $display("FAIL idle_awready: got %b required 1", awready); end
  endtask

  task automatic test_incr();
    logic [7:0] id; logic [1:0] resp; logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      bd[i] = 32'h11111111 * (i + 1); bs[i] = 4'hF; bl[i] = (i == 3);
    end
    send_aw(8'h5A, 32'h10, 8'd3, 2'b01);
    send_w(32'h10, 3, 2'b01, 4);
    tests++; if (bvalid !== 1'b1) begin fails++; $display("FAIL incr_b_latency: bvalid=%b required 1", bvalid); end
    get_b(0, id, resp);
    tests++; if (id !== 8'h5A)    begin fails++; $display("FAIL incr_bid: got %h required 5a", id); end
    tests++; if (resp !== 2'b00)  begin fails++; $display("FAIL incr_bresp: got %b required 00", resp); end
    for (int i = 0; i < 4; i++) begin
      rd(10'(4 + i), d);
      tests++;
      if (d !== 32'h11111111 * (i + 1)) begin
        fails++; $display("FAIL incr_word%0d: got %h required %h", 4 + i, d, 32'h11111111 * (i + 1));
      end
    end
  endtask

  task automatic test_fixed();
    logic [7:0] id; logic [1:0] resp; logic [31:0] d;
    bd[0] = 32'hAAAA0000; bs[0] = 4'hF; bl[0] = 1'b0;
    bd[1] = 32'h0000BBBB; bs[1] = 4'h3; bl[1] = 1'b1;
    send_aw(8'h21, 32'h20, 8'd1, 2'b00);
    send_w(32'h20, 1, 2'b00, 2);
    get_b(1, id, resp);
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL fixed_bresp: got %b required 00", resp); end
    rd(10'd8, d);
    tests++; if (d !== 32'hAAAABBBB) begin fails++; $display("FAIL fixed_word8: got %h required aaaabbbb", d); end
  endtask

  task automatic test_wlast_err();
    logic [7:0] id; logic [1:0] resp; logic [31:0] d;
    fill(2, 1'b1);
    bl[0] = 1'b0; bl[1] = 1'b1; bl[2] = 1'b0;
    send_aw(8'hC3, 32'h80, 8'd2, 2'b01);
    send_w(32'h80, 2, 2'b01, 3);
    tests++; if (bvalid !== 1'b1) begin fails++; $display("FAIL wlast_bvalid: got %b required 1", bvalid); end
    get_b(0, id, resp);
    tests++; if (resp !== 2'b10) begin fails++; $display("FAIL wlast_bresp: got %b required 10", resp); end
    tests++; if (id !== 8'hC3)   begin fails++; $display("FAIL wlast_bid: got %h required c3", id); end
    rd(10'd34, d);
    tests++; if (d !== bd[2]) begin fails++; $display("FAIL wlast_word34: got %h required %h", d, bd[2]); end
  endtask

  task automatic test_wrap_index();
    logic [7:0] id; logic [1:0] resp; logic [31:0] d;
    fill(1, 1'b1);
    send_aw(8'h01, 32'hFFC, 8'd1, 2'b01);
    send_w(32'hFFC, 1, 2'b01, 2);
    get_b(0, id, resp);
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL wrapidx_bresp: got %b required 00", resp); end
    rd(10'h3FF, d);
    tests++; if (d !== bd[0]) begin fails++; $display("FAIL wrapidx_word3ff: got %h required %h", d, bd[0]); end
    rd(10'h000, d);
    tests++; if (d !== bd[1]) begin fails++; $display("FAIL wrapidx_word0: got %h required %h", d, bd[1]); end
  endtask

  task automatic test_bresp_hold();
    int n;
    fill(0, 1'b1);
    send_aw(8'h33, 32'h40, 8'd0, 2'b01);
    send_w(32'h40, 0, 2'b01, 1);
    for (int c = 0; c < 5; c++) begin
      tests++; if (bvalid !== 1'b1)  begin fails++; $display("FAIL hold_bvalid c%0d: got %b required 1", c, bvalid); end
      tests++; if (bid !== 8'h33)    begin fails++; $display("FAIL hold_bid c%0d: got %h required 33", c, bid); end
      tests++; if (bresp !== 2'b00)  begin fails++; $display("FAIL hold_bresp c%0d: got %b required 00", c, bresp); end
      tests++; if (awready !== 1'b0) begin fails++; $display("FAIL hold_awready c%0d: got %b required 0", c, awready); end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    tests++; if (awready !== 1'b1) begin fails++; $display("FAIL hold_awready_after: got %b required 1", awready); end
    tests++; if (bvalid !== 1'b0)  begin fails++; $display("FAIL hold_bvalid_after: got %b required 0", bvalid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] id; logic [1:0] resp; logic [31:0] d;
    bit seen;
    fill(7, 1'b1);
    send_aw(8'h77, 32'h200, 8'd7, 2'b01);
    send_w(32'h200, 7, 2'b01, 2);
    wdata = bd[2]; wstrb = bs[2]; wlast = 1'b0; wvalid = 1'b1;
    #2 reset = 1'b1;
    #1;
    tests++; if (awready !== 1'b0) begin fails++; $display("FAIL midrst_awready: got %b required 0", awready); end
    tests++; if (wready !== 1'b0)  begin fails++; $display("FAIL midrst_wready: got %b required 0", wready); end
    @(negedge clk);
    reset = 1'b0; wvalid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bvalid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    tests++; if (seen) begin fails++; $display("FAIL midrst_no_b: bvalid seen=1 required 0"); end
    rd(10'd128, d);
    tests++; if (d !== bd[0]) begin fails++; $display("FAIL midrst_word128: got %h required %h", d, bd[0]); end
    rd(10'd129, d);
    tests++; if (d !== bd[1]) begin fails++; $display("FAIL midrst_word129: got %h required %h", d, bd[1]); end
    fill(3, 1'b1);
    send_aw(8'h12, 32'h300, 8'd3, 2'b01);
    send_w(32'h300, 3, 2'b01, 4);
    get_b(0, id, resp);
    tests++; if (id !== 8'h12)   begin fails++; $display("FAIL midrst_next_bid: got %h required 12", id); end
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL midrst_next_bresp: got %b required 00", resp); end
  endtask

  task automatic test_long();
    logic [7:0] id; logic [1:0] resp;
    fill(255, 1'b0);
    send_aw(8'hEE, 32'h400, 8'd255, 2'b01);
    send_w(32'h400, 255, 2'b01, 256);
    get_b(2, id, resp);
    tests++; if (resp !== 2'b00) begin fails++; $display("FAIL long_bresp: got %b required 00", resp); end
    tests++; if (id !== 8'hEE)   begin fails++; $display("FAIL long_bid: got %h required ee", id); end
  endtask

  task automatic test_random();
    logic [7:0] id; logic [1:0] resp; logic [31:0] d;
    logic [7:0] rid; logic [31:0] raddr; logic [1:0] rburst; int len;
    for (int k = 0; k < 12; k++) begin
      len    = $urandom_range(0, 15);
      rid    = 8'($urandom);
      raddr  = $urandom;
      rburst = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
      fill(len, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        int j;
        j = $urandom_range(0, len);
        bl[j] = ~bl[j];
      end
      send_aw(rid, raddr, 8'(len), rburst);
      send_w(raddr, len, rburst, len + 1);
      get_b($urandom_range(0, 3), id, resp);
      tests++; if (id !== rid) begin fails++; $display("FAIL rand%0d_bid: got %h required %h", k, id, rid); end
      tests++;
      if (resp !== (exp_err ? 2'b10 : 2'b00)) begin
        fails++; $display("FAIL rand%0d_bresp: got %b required %b", k, resp, exp_err ? 2'b10 : 2'b00);
      end
    end
    for (int w = 0; w < 1024; w++) begin
      if (ref_mask[w] != 32'h0) begin
        rd(10'(w), d);
        tests++;
        if ((d & ref_mask[w]) !== (ref_mem[w] & ref_mask[w])) begin
          fails++; $display("FAIL mem_word%0d: got %h required %h mask %h", w, d, ref_mem[w], ref_mask[w]);
        end
      end
    end
  endtask

  initial begin
    for (int w = 0; w < 1024; w++) begin
      ref_mem[w] = '0; ref_mask[w] = '0;
    end
    test_reset();
    test_incr();
    test_fixed();
    test_wlast_err();
    test_wrap_index();
    test_bresp_hold();
    test_reset_mid();
    test_long();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
